bus_datapath_seq: RTL and testbench
===================================

// Module: bus_datapath_seq
// PURPOSE
//  Parametrised successor to the phase-1 bus datapath: NUM_REGS x DATA_W register file, Y/Z(hi,lo)/HI/LO
//  and an internal ALU driven by a built-in micro-step sequencer instead of external one-hot strobes.
//  One start pulse runs a full three-operand op (Rb -> Y, Y op Rc -> Z, Z -> Ra or HI/LO).
//  Adds iterative MUL/DIV (shift-add / restoring) and an external load/read port for register init.
// PARAMETERS
//  DATA_W    32  register/bus width (>=8, power of 2)
//  NUM_REGS  16  general registers (power of 2); REG_AW = $clog2(NUM_REGS)
// PORTS
//  clock     in   1          system clock, all state updates on rising edge
//  clear     in   1          asynchronous, active-low reset (clear=0 resets)
//  start     in   1          begin op; sampled only in IDLE
//  opcode    in   4          0 ADD,1 SUB,2 AND,3 OR,4 SHL,5 SHR,6 SRA,7 MUL,8 DIV; 9-15 illegal
//  ra/rb/rc  in   REG_AW     dest / source A / source B register indices
//  ld_en     in   1          external register load, honoured only in IDLE
//  ld_addr   in   REG_AW     load index
//  ld_data   in   DATA_W     load value
//  rd_addr   in   REG_AW     debug read index
//  rd_data   out  DATA_W     combinational R[rd_addr]
//  hi, lo    out  DATA_W     HI/LO register contents
//  busy      out  1          state != IDLE
//  done      out  1          one-cycle registered pulse after writeback
//  err       out  1          one-cycle pulse with done for illegal opcode
// BEHAVIOUR
//  - Reset (clear=0, any time incl. mid-op): all R, Y, Zhi, Zlo, HI, LO, counter = 0; state IDLE; busy=done=err=0.
//  - FSM: IDLE -> LOADY -> EXEC -> [ITER] -> WB -> IDLE.
//    IDLE:  start=1 -> LOADY; latch opcode/ra/rb/rc (later input changes ignored).
//    LOADY: Y <= R[rb].
//    EXEC:  single-cycle ops: Z <= {0, Y op R[rc]}; MUL/DIV load operands, cnt<=DATA_W-1 -> ITER; illegal -> WB.
//    ITER:  one shift-add / restore step per cycle; cnt==0 -> WB. DIV by 0 skips ITER.
//    WB:    ALU ops R[ra] <= Zlo; MUL/DIV HI <= Zhi, LO <= Zlo (no R write); illegal no write.
//           done (and err if illegal) set at this edge -> high exactly 1 cycle, state back in IDLE.
//  - Latency start-edge to writeback edge: 3 cycles single-cycle ops; DATA_W+3 MUL/DIV; 3 for DIV by 0.
//  - Arithmetic: ADD/SUB modulo 2^DATA_W, no flags. Shifts use R[rc][$clog2(DATA_W)-1:0]; SRA sign-fills.
//    MUL unsigned, {Zhi,Zlo} = Y*R[rc] (2*DATA_W). DIV unsigned: Zlo=Y/R[rc], Zhi=Y%R[rc];
//    divisor 0 -> Zlo = all ones, Zhi = Y.
//  - Simultaneous: start ignored when busy (no queueing). ld_en ignored when busy.
//    ld_en & start in same IDLE cycle: load commits at that edge, so operand reads in LOADY/EXEC see it.
//    ra may equal rb/rc; sources read before WB so result is well-defined.
// CONFIGURATION
//  R0_ZERO_EN defined: R0 hard-wired to 0; writes to R0 via ld_en or WB discarded; reads return 0.
//  undefined: R0 is an ordinary register.
// TESTING
//  1 clear=0 mid-MUL (ITER) -> same cycle busy=0, hi=lo=0, all R read 0; next start runs normally.
//  2 R1=7, R2=5, ADD ra=3 rb=1 rc=2 -> done 3 cycles after start edge, R3=12; SUB -> R3=2.
//  3 R4=0x80000000, R5=4: SRA -> 0xF8000000, SHR -> 0x08000000, SHL -> 0.
//  4 R1=0xFFFFFFFF, R2=2, MUL -> done at DATA_W+3 (35), hi=1, lo=0xFFFFFFFE.
//  5 DIV 100/7 -> lo=14, hi=2; DIV 9/0 -> lo=0xFFFFFFFF, hi=9 in 3 cycles.
//  6 opcode 12 -> done & err together, no R/HI/LO change; start pulsed while busy ignored;
//    R0_ZERO_EN: ld R0=5 then rd_addr=0 -> 0.

Source files
------------

// File: rtl/bus_datapath_seq.sv
// bus_datapath_seq: register-file datapath with an internal ALU sequenced by its own FSM.
// A single start pulse runs Rb -> Y, Y op Rc -> Z, then Z -> Ra (ALU ops) or Z -> HI/LO (MUL/DIV).
// MUL is shift-add and DIV is restoring, one step per cycle; an external port loads/reads registers.
//
// Ports:
//   clock_i            system clock, rising edge
//   clear_ni           asynchronous active-low reset
//   start_i            begin an op (sampled only when idle)
//   opcode_i           0 ADD,1 SUB,2 AND,3 OR,4 SHL,5 SHR,6 SRA,7 MUL,8 DIV, others illegal
//   ra_i/rb_i/rc_i     destination / source A / source B register indices
//   ld_en_i/ld_addr_i/ld_data_i  external register load (honoured only when idle)
//   rd_addr_i/rd_data_o          combinational debug read
//   hi_o/lo_o          HI/LO registers
//   busy_o             op in progress
//   done_o             one-cycle pulse after writeback
//   err_o              one-cycle pulse with done_o for an illegal opcode
//
// Configuration macro R0_ZERO_EN: when defined, R0 is hard-wired to zero (writes discarded).
module bus_datapath_seq #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  localparam int unsigned REG_AW  = $clog2(NUM_REGS),
  localparam int unsigned SH_W    = $clog2(DATA_W)
) (
  input  logic              clock_i,
  input  logic              clear_ni,
  input  logic              start_i,
  input  logic [3:0]        opcode_i,
  input  logic [REG_AW-1:0] ra_i,
  input  logic [REG_AW-1:0] rb_i,
  input  logic [REG_AW-1:0] rc_i,
  input  logic              ld_en_i,
  input  logic [REG_AW-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpShl = 4'd4;
  localparam logic [3:0] OpShr = 4'd5;
  localparam logic [3:0] OpSra = 4'd6;
  localparam logic [3:0] OpMul = 4'd7;
  localparam logic [3:0] OpDiv = 4'd8;

  typedef enum logic [2:0] {StIdle, StLoadY, StExec, StIter, StWb} state_e;

  state_e              state_q;
  logic [3:0]          op_q;
  logic [REG_AW-1:0]   ra_q, rb_q, rc_q;
  logic [DATA_W-1:0]   rf_q [NUM_REGS];
  logic [DATA_W-1:0]   y_q, zhi_q, zlo_q, hi_q, lo_q;
  logic [SH_W-1:0]     cnt_q;
  logic                done_q, err_q;

  logic [DATA_W-1:0]   rb_val, rc_val, alu_res;
  logic [SH_W-1:0]     shamt;
  logic                op_alu, op_illegal;
  logic                ld_wr_ok, wb_wr_ok;

  // Iteration step helpers
  logic [DATA_W-1:0]   mul_add;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_rem_sh, div_diff;
  logic                div_ge;

`ifdef R0_ZERO_EN
  // R0 resets to zero and is never written, so reads of it always return zero.
  assign ld_wr_ok = (ld_addr_i != '0);
  assign wb_wr_ok = (ra_q != '0);
`else
  assign ld_wr_ok = 1'b1;
  assign wb_wr_ok = 1'b1;
`endif

  // The register file cannot change while busy, so sources are read live from the latched indices.
  assign rb_val     = rf_q[rb_q];
  assign rc_val     = rf_q[rc_q];
  assign shamt      = rc_val[SH_W-1:0];
  assign op_alu     = (op_q <= OpSra);
  assign op_illegal = (op_q > OpDiv);

  always_comb begin
    alu_res = '0;
    case (op_q)
      OpAdd:   alu_res = y_q + rc_val;
      OpSub:   alu_res = y_q - rc_val;
      OpAnd:   alu_res = y_q & rc_val;
      OpOr:    alu_res = y_q | rc_val;
      OpShl:   alu_res = y_q << shamt;
      OpShr:   alu_res = y_q >> shamt;
      OpSra:   alu_res = $signed(y_q) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // Shift-add: {Zhi,Zlo} holds {partial product, remaining multiplier}, shifted right each step.
  assign mul_add = zlo_q[0] ? rc_val : '0;
  assign mul_sum = {1'b0, zhi_q} + {1'b0, mul_add};

  // Restoring: Zhi is the partial remainder, Zlo shifts dividend bits out and quotient bits in.
  // The partial remainder stays below the divisor, so the W+1-bit difference sign is exact.
  assign div_rem_sh = {zhi_q, zlo_q[DATA_W-1]};
  assign div_diff   = div_rem_sh - {1'b0, rc_val};
  assign div_ge     = ~div_diff[DATA_W];

  always_ff @(posedge clock_i or negedge clear_ni) begin
    if (!clear_ni) begin
      state_q <= StIdle;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      y_q     <= '0;
      zhi_q   <= '0;
      zlo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ld_en_i && ld_wr_ok) begin
            rf_q[ld_addr_i] <= ld_data_i;
          end
          if (start_i) begin
            op_q    <= opcode_i;
            ra_q    <= ra_i;
            rb_q    <= rb_i;
            rc_q    <= rc_i;
            state_q <= StLoadY;
          end
        end
        StLoadY: begin
          y_q     <= rb_val;
          state_q <= StExec;
        end
        StExec: begin
          if (op_alu) begin
            zhi_q   <= '0;
            zlo_q   <= alu_res;
            state_q <= StWb;
          end else if (op_q == OpMul) begin
            zhi_q   <= '0;
            zlo_q   <= y_q;
            cnt_q   <= SH_W'(DATA_W - 1);
            state_q <= StIter;
          end else if (op_q == OpDiv) begin
            if (rc_val == '0) begin
              zhi_q   <= y_q;
              zlo_q   <= '1;
              state_q <= StWb;
            end else begin
              zhi_q   <= '0;
              zlo_q   <= y_q;
              cnt_q   <= SH_W'(DATA_W - 1);
              state_q <= StIter;
            end
          end else begin
            state_q <= StWb;
          end
        end
        StIter: begin
          if (op_q == OpMul) begin
            zhi_q <= mul_sum[DATA_W:1];
            zlo_q <= {mul_sum[0], zlo_q[DATA_W-1:1]};
          end else begin
            zhi_q <= div_ge ? div_diff[DATA_W-1:0] : div_rem_sh[DATA_W-1:0];
            zlo_q <= {zlo_q[DATA_W-2:0], div_ge};
          end
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= StWb;
          end
        end
        StWb: begin
          if (op_alu && wb_wr_ok) begin
            rf_q[ra_q] <= zlo_q;
          end else if (op_q == OpMul || op_q == OpDiv) begin
            hi_q <= zhi_q;
            lo_q <= zlo_q;
          end
          done_q  <= 1'b1;
          err_q   <= op_illegal;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rd_data_o = rf_q[rd_addr_i];
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign busy_o    = (state_q != StIdle);
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed bench for bus_datapath_seq (DATA_W=32, NUM_REGS=16). Expected results are pushed to a
// scoreboard queue as each op is launched and popped when done_o is seen.
module tb_bus_datapath_seq;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          clear_n;
  logic          start;
  logic [3:0]    opcode;
  logic [3:0]    ra, rb, rc;
  logic          ld_en;
  logic [3:0]    ld_addr;
  logic [DW-1:0] ld_data;
  logic [3:0]    rd_addr;
  logic [DW-1:0] rd_data, hi, lo;
  logic          busy, done, err;

  bus_datapath_seq #(.DATA_W(32), .NUM_REGS(16)) dut (
    .clock_i  (clk),
    .clear_ni (clear_n),
    .start_i  (start),
    .opcode_i (opcode),
    .ra_i     (ra),
    .rb_i     (rb),
    .rc_i     (rc),
    .ld_en_i  (ld_en),
    .ld_addr_i(ld_addr),
    .ld_data_i(ld_data),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data),
    .hi_o     (hi),
    .lo_o     (lo),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err)
  );

  always #5 clk = ~clk;

  // kind 0: R[idx] == val; kind 1: hi/lo; kind 2: illegal, R[idx] == val and hi/lo unchanged
  typedef struct packed {
    logic [1:0]    kind;
    logic [3:0]    idx;
    logic [DW-1:0] val;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] idx, input logic [DW-1:0] exp);
    rd_addr = idx;
    #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic load(input logic [3:0] a, input logic [DW-1:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic push(input logic [1:0] k, input logic [3:0] idx, input logic [DW-1:0] v,
                      input logic [DW-1:0] h, input logic [DW-1:0] l);
    exp_t e;
    e.kind = k;
    e.idx  = idx;
    e.val  = v;
    e.hi   = h;
    e.lo   = l;
    sb.push_back(e);
  endtask

  // Launch an op, wait (bounded) for done, then pop and compare. intrude drives a start and a
  // load while busy; neither may have any effect.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] c, input int exp_lat,
                        input logic exp_err, input bit intrude);
    int   lat;
    int   extra;
    exp_t e;
    start  = 1'b1;
    opcode = op;
    ra     = a;
    rb     = b;
    rc     = c;
    tick();
    start  = 1'b0;
    ld_en  = 1'b0;
    opcode = 4'hF;
    ra     = 4'hF;
    rb     = 4'hE;
    rc     = 4'hD;
    lat    = 0;
    do begin
      if (intrude && lat == 4) begin
        start = 1'b1; opcode = 4'd0; ra = 4'd3; rb = 4'd1; rc = 4'd1;
        ld_en = 1'b1; ld_addr = 4'd13; ld_data = 32'h55;
      end
      tick();
      start = 1'b0;
      ld_en = 1'b0;
      lat++;
    end while (!done && lat < 200);
    chk({tag, "/latency"}, DW'(lat), DW'(exp_lat));
    chk({tag, "/err"}, DW'(err), DW'(exp_err));
    chk({tag, "/busy_at_done"}, DW'(busy), '0);
    if (sb.size() == 0) begin
      chk({tag, "/scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      if (e.kind == 2'd1) begin
        chk({tag, "/hi"}, hi, e.hi);
        chk({tag, "/lo"}, lo, e.lo);
      end else begin
        rd_chk({tag, "/reg"}, e.idx, e.val);
        if (e.kind == 2'd2) begin
          chk({tag, "/hi_kept"}, hi, e.hi);
          chk({tag, "/lo_kept"}, lo, e.lo);
        end
      end
    end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) extra++;
    end
    chk({tag, "/extra_done"}, DW'(extra), '0);
  endtask

  logic [63:0]   prod;
  logic [DW-1:0] q_m, r_m, a_m, b_m;

  initial begin
    clear_n = 1'b0; start = 1'b0; opcode = '0; ra = '0; rb = '0; rc = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    #12;
    chk("reset/busy", DW'(busy), '0);
    chk("reset/done", DW'(done), '0);
    chk("reset/err", DW'(err), '0);
    chk("reset/hi", hi, '0);
    clear_n = 1'b1;
    tick();

    // Single-cycle ALU ops
    load(4'd1, 32'd7);
    load(4'd2, 32'd5);
    push(2'd0, 4'd3, 32'd12, '0, '0); run_op("add", 4'd0, 4'd3, 4'd1, 4'd2, 3, 1'b0, 1'b0);
    push(2'd0, 4'd3, 32'd2, '0, '0);  run_op("sub", 4'd1, 4'd3, 4'd1, 4'd2, 3, 1'b0, 1'b0);
    push(2'd0, 4'd3, 32'd5, '0, '0);  run_op("and", 4'd2, 4'd3, 4'd1, 4'd2, 3, 1'b0, 1'b0);
    push(2'd0, 4'd3, 32'd7, '0, '0);  run_op("or", 4'd3, 4'd3, 4'd1, 4'd2, 3, 1'b0, 1'b0);

    // Shifts
    load(4'd4, 32'h8000_0000);
    load(4'd5, 32'd4);
    push(2'd0, 4'd6, 32'hF800_0000, '0, '0); run_op("sra", 4'd6, 4'd6, 4'd4, 4'd5, 3, 1'b0, 1'b0);
    push(2'd0, 4'd6, 32'h0800_0000, '0, '0); run_op("shr", 4'd5, 4'd6, 4'd4, 4'd5, 3, 1'b0, 1'b0);
    push(2'd0, 4'd6, 32'h0, '0, '0);         run_op("shl", 4'd4, 4'd6, 4'd4, 4'd5, 3, 1'b0, 1'b0);

    // Load and start in the same idle cycle: the op must see the freshly loaded R11
    ld_en = 1'b1; ld_addr = 4'd11; ld_data = 32'd40;
    push(2'd0, 4'd12, 32'd45, '0, '0); run_op("ld_start", 4'd0, 4'd12, 4'd11, 4'd2, 3, 1'b0, 1'b0);

    // Destination equal to both sources
    push(2'd0, 4'd2, 32'd10, '0, '0); run_op("ra_eq_rb", 4'd0, 4'd2, 4'd2, 4'd2, 3, 1'b0, 1'b0);

    // MUL boundary case, with a start and a load attempted while busy
    load(4'd1, 32'hFFFF_FFFF);
    load(4'd2, 32'd2);
    push(2'd1, 4'd0, '0, 32'd1, 32'hFFFF_FFFE);
    run_op("mul_max", 4'd7, 4'd0, 4'd1, 4'd2, DW + 3, 1'b0, 1'b1);
    rd_chk("busy_start_ignored", 4'd3, 32'd7);
    rd_chk("busy_load_ignored", 4'd13, 32'd0);

    a_m = 32'h1234_5678; b_m = 32'h9ABC_DEF0;
    prod = 64'(a_m) * 64'(b_m);
    load(4'd7, a_m);
    load(4'd8, b_m);
    push(2'd1, 4'd0, '0, prod[63:32], prod[31:0]);
    run_op("mul_mix", 4'd7, 4'd0, 4'd7, 4'd8, DW + 3, 1'b0, 1'b0);

    // DIV
    load(4'd7, 32'd100);
    load(4'd8, 32'd7);
    push(2'd1, 4'd0, '0, 32'd2, 32'd14); run_op("div", 4'd8, 4'd0, 4'd7, 4'd8, DW + 3, 1'b0, 1'b0);
    load(4'd9, 32'd9);
    push(2'd1, 4'd0, '0, 32'd9, 32'hFFFF_FFFF);
    run_op("div_zero", 4'd8, 4'd0, 4'd9, 4'd10, 3, 1'b0, 1'b0);
    a_m = 32'hDEAD_BEEF; b_m = 32'h0000_1234;
    q_m = a_m / b_m;
    r_m = a_m % b_m;
    load(4'd7, a_m);
    load(4'd8, b_m);
    push(2'd1, 4'd0, '0, r_m, q_m); run_op("div_mix", 4'd8, 4'd0, 4'd7, 4'd8, DW + 3, 1'b0, 1'b0);

    // Illegal opcode: done and err together, nothing written
    push(2'd2, 4'd3, 32'd7, r_m, q_m);
    run_op("illegal", 4'd12, 4'd3, 4'd1, 4'd2, 3, 1'b1, 1'b0);

    // R0 behaviour depends on the build option
    load(4'd0, 32'd5);
`ifdef R0_ZERO_EN
    rd_chk("r0_load", 4'd0, 32'd0);
`else
    rd_chk("r0_load", 4'd0, 32'd5);
`endif

    // Asynchronous clear in the middle of a MUL iteration
    start = 1'b1; opcode = 4'd7; ra = 4'd0; rb = 4'd1; rc = 4'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_mul/busy_before", DW'(busy), 32'd1);
    #2;
    clear_n = 1'b0;
    #1;
    chk("clear/busy", DW'(busy), '0);
    chk("clear/hi", hi, '0);
    chk("clear/lo", lo, '0);
    for (int i = 0; i < 16; i++) begin
      rd_chk("clear/reg", 4'(i), '0);
    end
    tick();
    clear_n = 1'b1;
    tick();
    load(4'd1, 32'd7);
    load(4'd2, 32'd5);
    push(2'd0, 4'd3, 32'd12, '0, '0); run_op("after_clear", 4'd0, 4'd3, 4'd1, 4'd2, 3, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
